// File: rtl/loader_pkg.sv
// Shared types, default sizing and width helper for the program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package loader_pkg;

    localparam int unsigned DEF_INSTR_WIDTH = 32;
    localparam int unsigned DEF_IN_WIDTH    = 8;
    localparam int unsigned DEF_DEPTH       = 64;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    // Bits needed to index n items; never less than one so counters stay legal.
    function automatic int unsigned width_for(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// Gathers IN_WIDTH beats into one INSTR_WIDTH word, little-endian (first beat in the LSBs).
// Latency: word_o/word_complete_o are combinational with the accepting beat.
// Backpressure: none; beat_vld_i must only be high for beats the parent has accepted.
module word_assembler
    import loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   clear_i,
    input  logic                   beat_vld_i,
    input  logic [IN_WIDTH-1:0]    beat_dat_i,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   word_complete_o
);

    localparam int unsigned BEATS = INSTR_WIDTH / IN_WIDTH;
    localparam int unsigned CNT_W = width_for(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;

    // Shift each new beat in at the top so after BEATS beats the first one sits in the LSBs.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        asm_d      = asm_q;
        if (clear_i) begin
            beat_cnt_d = '0;
            asm_d      = '0;
        end else if (beat_vld_i) begin
            asm_d = (asm_q >> IN_WIDTH) |
                    (INSTR_WIDTH'(beat_dat_i) << (INSTR_WIDTH - IN_WIDTH));
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + CNT_W'(1);
        end
    end

    // Assembly state registers.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            beat_cnt_q <= '0;
            asm_q      <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            asm_q      <= asm_d;
        end
    end

    // The parent captures the next-state word so the final beat is included.
    assign word_o          = asm_d;
    assign word_complete_o = beat_vld_i && !clear_i && (beat_cnt_q == LAST_BEAT);

endmodule

// File: rtl/program_loader.sv
// Loads a program beat-by-beat into instruction memory, then releases the CPU.
// Latency: write strobe one cycle after the last beat of a word; one bubble per word.
// Backpressure: data_ready_out is high only in LOAD, so input stalls during each commit.
module program_loader
    import loader_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int unsigned IN_WIDTH    = DEF_IN_WIDTH,
    parameter int unsigned DEPTH       = DEF_DEPTH,
    localparam int unsigned ADDR_W     = width_for(DEPTH)
) (
    input  logic                   clock_in,
    input  logic                   reset_in,
    input  logic                   start_in,
    input  logic [ADDR_W:0]        length_in,
    input  logic [IN_WIDTH-1:0]    data_in,
    input  logic                   data_valid_in,
    output logic                   data_ready_out,
    output logic                   mem_write_enable_out,
    output logic [ADDR_W-1:0]      mem_address_out,
    output logic [INSTR_WIDTH-1:0] mem_data_out,
    output logic [ADDR_W:0]        word_count_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out,
    output logic                   cpu_run_out
);

    localparam int unsigned LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

    state_t                 state_q, state_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] data_q, data_d;

    logic                   can_start;
    logic                   len_legal;
    logic                   beat_accept;
    logic                   asm_clear;
    logic                   word_complete;
    logic [INSTR_WIDTH-1:0] asm_word;

    // A new load may only begin from a resting state; illegal lengths divert to ERROR.
    assign can_start   = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);
    assign len_legal   = (length_in != '0) && (length_in <= DEPTH_LEN);
    assign asm_clear   = can_start && start_in && len_legal;
    assign beat_accept = data_valid_in && (state_q == ST_LOAD);

    word_assembler #(
        .INSTR_WIDTH (INSTR_WIDTH),
        .IN_WIDTH    (IN_WIDTH)
    ) u_asm (
        .clock_in        (clock_in),
        .reset_in        (reset_in),
        .clear_i         (asm_clear),
        .beat_vld_i      (beat_accept),
        .beat_dat_i      (data_in),
        .word_o          (asm_word),
        .word_complete_o (word_complete)
    );

    // Next-state logic; the write address/data are captured on entry to COMMIT and then held.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_in) begin
                    if (len_legal) begin
                        state_d    = ST_LOAD;
                        len_d      = length_in;
                        word_cnt_d = '0;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_LOAD: begin
                if (word_complete) begin
                    state_d = ST_COMMIT;
                    // The length check keeps the index below DEPTH, so the top bit is always 0 here.
                    addr_d  = word_cnt_q[ADDR_W-1:0];
                    data_d  = asm_word;
                end
            end
            ST_COMMIT: begin
                word_cnt_d = word_cnt_q + LEN_W'(1);
                state_d    = ((word_cnt_q + LEN_W'(1)) == len_q) ? ST_DONE : ST_LOAD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and write-port registers; reset abandons any partial load.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
        end
    end

    assign data_ready_out       = (state_q == ST_LOAD);
    assign mem_write_enable_out = (state_q == ST_COMMIT);
    assign mem_address_out      = addr_q;
    assign mem_data_out         = data_q;
    assign word_count_out       = word_cnt_q;
    assign busy_out             = (state_q == ST_LOAD) || (state_q == ST_COMMIT);
    assign done_out             = (state_q == ST_DONE);
    assign error_out            = (state_q == ST_ERROR);
    assign cpu_run_out          = (state_q == ST_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: default instance plus a 16/4 instance.
// Latency: n/a.
// Backpressure: n/a.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset_in;
    always #5 clk = ~clk;

    // Default instance (32-bit words, 8-bit beats, 64 words)
    logic        start_in, data_valid_in;
    logic [6:0]  length_in;
    logic [7:0]  data_in;
    logic        data_ready_out, mem_we, busy_out, done_out, error_out, cpu_run_out;
    logic [5:0]  mem_addr;
    logic [31:0] mem_data;
    logic [6:0]  word_count_out;

    program_loader u_dut (
        .clock_in             (clk),
        .reset_in             (reset_in),
        .start_in             (start_in),
        .length_in            (length_in),
        .data_in              (data_in),
        .data_valid_in        (data_valid_in),
        .data_ready_out       (data_ready_out),
        .mem_write_enable_out (mem_we),
        .mem_address_out      (mem_addr),
        .mem_data_out         (mem_data),
        .word_count_out       (word_count_out),
        .busy_out             (busy_out),
        .done_out             (done_out),
        .error_out            (error_out),
        .cpu_run_out          (cpu_run_out)
    );

    // Narrow instance (16-bit words, 4-bit beats)
    logic        n_start, n_valid, n_ready, n_we, n_busy, n_done, n_error, n_run;
    logic [6:0]  n_length, n_count;
    logic [3:0]  n_data_in;
    logic [5:0]  n_addr;
    logic [15:0] n_data;

    program_loader #(.INSTR_WIDTH(16), .IN_WIDTH(4)) u_dut2 (
        .clock_in             (clk),
        .reset_in             (reset_in),
        .start_in             (n_start),
        .length_in            (n_length),
        .data_in              (n_data_in),
        .data_valid_in        (n_valid),
        .data_ready_out       (n_ready),
        .mem_write_enable_out (n_we),
        .mem_address_out      (n_addr),
        .mem_data_out         (n_data),
        .word_count_out       (n_count),
        .busy_out             (n_busy),
        .done_out             (n_done),
        .error_out            (n_error),
        .cpu_run_out          (n_run)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Stimulus program and observations from the last driven load
    logic [7:0]  beats[$];
    int          obs_a[$];
    logic [31:0] obs_d[$];
    int          obs_cyc[$];
    int          acc_cyc[$];
    int          done_cyc;
    bit          ready_in_commit;
    bit          timed_out;
    bit          first_run;
    logic [2:0]  first_flags;

    // Reference: word k is beats 4k..4k+3 placed little-endian.
    function automatic logic [31:0] model_word(input int k);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) w = w | (32'(beats[k*4+j]) << (8*j));
        return w;
    endfunction

    // Start a load of len words and stream the beats queue with random valid gaps.
    task automatic drive_load(input int len, input int gap_pct, input bit poke_start);
        int idx = 0;
        int cyc = 0;
        obs_a.delete(); obs_d.delete(); obs_cyc.delete(); acc_cyc.delete();
        done_cyc = -1; ready_in_commit = 0; timed_out = 0;
        @(negedge clk);
        start_in = 1'b1; length_in = 7'(len); data_valid_in = 1'b0;
        for (int n = 0; n < 5000; n++) begin
            @(negedge clk);
            cyc++;
            start_in = 1'b0;
            if (cyc == 1) begin
                first_run   = cpu_run_out;
                first_flags = {busy_out, error_out, data_ready_out};
            end
            if (mem_we) begin
                obs_a.push_back(int'(mem_addr));
                obs_d.push_back(mem_data);
                obs_cyc.push_back(cyc);
                if (data_ready_out) ready_in_commit = 1;
            end
            if (done_out || error_out) begin
                done_cyc = cyc;
                break;
            end
            data_valid_in = (idx < beats.size()) && ($urandom_range(99) >= gap_pct);
            data_in = (data_valid_in && data_ready_out) ? beats[idx] : 8'($urandom);
            if (data_valid_in && data_ready_out) begin
                if (idx % 4 == 3) acc_cyc.push_back(cyc);
                idx++;
            end
            if (poke_start && busy_out && $urandom_range(9) == 0) begin
                start_in = 1'b1; length_in = 7'd1;
            end
        end
        if (done_cyc < 0) timed_out = 1;
        data_valid_in = 1'b0; start_in = 1'b0;
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        #1;
        n_assert++;
        if ({data_ready_out, mem_we, mem_addr, mem_data, word_count_out, busy_out, done_out, error_out, cpu_run_out} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero outputs, required all 0");
        end
        n_assert++;
        if ({n_ready, n_we, n_addr, n_data, n_count, n_busy, n_done, n_error, n_run} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_narrow: got nonzero outputs, required all 0");
        end
        repeat (2) @(negedge clk);
        reset_in = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_d [2] = '{32'h44332211, 32'h88776655};
        beats = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        drive_load(2, 0, 0);
        n_assert++;
        if (timed_out || obs_a.size() != 2) begin
            n_fail++; $display("FAIL b2b_writes: got %0d writes (timeout=%0d), required 2", obs_a.size(), timed_out);
        end else begin
            for (int k = 0; k < 2; k++) begin
                n_assert++;
                if (obs_a[k] != k || obs_d[k] !== exp_d[k]) begin
                    n_fail++; $display("FAIL b2b_word%0d: got addr %0d data %h, required addr %0d data %h", k, obs_a[k], obs_d[k], k, exp_d[k]);
                end
            end
            // Four beats plus one bubble per word: writes at cycles 5 and 10, done at 11.
            n_assert++;
            if (obs_cyc[0] != 5 || obs_cyc[1] != 10 || done_cyc != 11) begin
                n_fail++; $display("FAIL b2b_timing: got writes %0d,%0d done %0d, required 5,10 done 11", obs_cyc[0], obs_cyc[1], done_cyc);
            end
        end
        n_assert++;
        if ({done_out, cpu_run_out, busy_out, word_count_out} !== {1'b1, 1'b1, 1'b0, 7'd2}) begin
            n_fail++; $display("FAIL b2b_done: got done %b run %b busy %b count %0d, required 1 1 0 2", done_out, cpu_run_out, busy_out, word_count_out);
        end
    endtask

    task automatic test_error();
        @(negedge clk); start_in = 1'b1; length_in = 7'd0;
        @(negedge clk); start_in = 1'b0;
        n_assert++;
        if ({error_out, mem_we, data_ready_out, done_out, cpu_run_out} !== 5'b10000) begin
            n_fail++; $display("FAIL err_len0: got err/we/rdy/done/run %b, required 10000", {error_out, mem_we, data_ready_out, done_out, cpu_run_out});
        end
        start_in = 1'b1; length_in = 7'd65;
        @(negedge clk); start_in = 1'b0; data_valid_in = 1'b1;
        repeat (2) @(negedge clk);
        data_valid_in = 1'b0;
        n_assert++;
        if ({error_out, mem_we, busy_out} !== 3'b100) begin
            n_fail++; $display("FAIL err_len65: got err/we/busy %b, required 100", {error_out, mem_we, busy_out});
        end
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back(8'($urandom));
        drive_load(1, 0, 0);
        n_assert++;
        if (first_flags !== 3'b101) begin
            n_fail++; $display("FAIL err_recover: got busy/err/rdy %b, required 101", first_flags);
        end
        n_assert++;
        if (timed_out || obs_a.size() != 1 || obs_d[0] !== model_word(0)) begin
            n_fail++; $display("FAIL err_recover_write: got %0d writes, required 1 with data %h", obs_a.size(), model_word(0));
        end
    endtask

    task automatic test_random_gaps();
        beats.delete();
        for (int i = 0; i < 12; i++) beats.push_back(8'($urandom));
        drive_load(3, 45, 0);
        n_assert++;
        if (timed_out || obs_a.size() != 3) begin
            n_fail++; $display("FAIL gaps_writes: got %0d writes, required 3", obs_a.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_assert++;
                if (obs_a[k] != k || obs_d[k] !== model_word(k) || obs_cyc[k] != acc_cyc[k] + 1) begin
                    n_fail++; $display("FAIL gaps_word%0d: got addr %0d data %h cyc %0d, required addr %0d data %h cyc %0d", k, obs_a[k], obs_d[k], obs_cyc[k], k, model_word(k), acc_cyc[k] + 1);
                end
            end
            n_assert++;
            if (done_cyc != obs_cyc[2] + 1) begin
                n_fail++; $display("FAIL gaps_done: got done cycle %0d, required %0d", done_cyc, obs_cyc[2] + 1);
            end
        end
        n_assert++;
        if (ready_in_commit) begin
            n_fail++; $display("FAIL gaps_ready_commit: got data_ready_out 1 during write, required 0");
        end
    endtask

    task automatic test_full_depth();
        int bad = 0;
        beats.delete();
        for (int i = 0; i < 256; i++) beats.push_back(8'(i));
        drive_load(64, 30, 1);
        n_assert++;
        if (first_run !== 1'b0) begin
            n_fail++; $display("FAIL restart_run: got cpu_run_out %b in first LOAD cycle, required 0", first_run);
        end
        n_assert++;
        if (timed_out || obs_a.size() != 64) begin
            n_fail++; $display("FAIL depth_writes: got %0d writes, required 64", obs_a.size());
        end else begin
            for (int k = 0; k < 64; k++)
                if (obs_a[k] != k || obs_d[k] !== model_word(k)) bad++;
            n_assert++;
            if (bad != 0 || obs_a[63] != 63) begin
                n_fail++; $display("FAIL depth_words: got %0d bad words, last addr %0d, required 0 bad, last addr 63", bad, obs_a[63]);
            end
        end
        n_assert++;
        if ({word_count_out, mem_addr, mem_data} !== {7'd64, 6'd63, model_word(63)}) begin
            n_fail++; $display("FAIL depth_hold: got count %0d addr %0d data %h, required 64 63 %h", word_count_out, mem_addr, mem_data, model_word(63));
        end
    endtask

    task automatic test_reset_midload();
        int idx = 0;
        beats.delete();
        for (int i = 0; i < 5; i++) beats.push_back(8'($urandom_range(255, 1)));
        @(negedge clk); start_in = 1'b1; length_in = 7'd4;
        @(negedge clk); start_in = 1'b0;
        for (int n = 0; n < 60 && idx < 5; n++) begin
            data_valid_in = data_ready_out;
            data_in = beats[idx];
            if (data_ready_out) idx++;
            @(negedge clk);
        end
        data_valid_in = 1'b0;
        n_assert++;
        if ({busy_out, word_count_out, mem_data} !== {1'b1, 7'd1, model_word(0)}) begin
            n_fail++; $display("FAIL midload_pre: got busy %b count %0d data %h, required 1 1 %h", busy_out, word_count_out, mem_data, model_word(0));
        end
        #2 reset_in = 1'b1;
        #1;
        n_assert++;
        if ({data_ready_out, mem_we, mem_addr, mem_data, word_count_out, busy_out, done_out, error_out, cpu_run_out} !== '0) begin
            n_fail++; $display("FAIL midload_async: got nonzero outputs under reset, required all 0");
        end
        @(negedge clk); reset_in = 1'b0;
        n_assert++;
        if (done_out !== 1'b0 || cpu_run_out !== 1'b0) begin
            n_fail++; $display("FAIL midload_notdone: got done %b run %b, required 0 0", done_out, cpu_run_out);
        end
        beats.delete();
        for (int i = 0; i < 4; i++) beats.push_back(8'($urandom));
        drive_load(1, 20, 0);
        n_assert++;
        if (timed_out || obs_a.size() != 1 || obs_a[0] != 0 || obs_d[0] !== model_word(0)) begin
            n_fail++; $display("FAIL midload_fresh: got %0d writes, required 1 at addr 0 data %h", obs_a.size(), model_word(0));
        end
    endtask

    task automatic test_narrow();
        logic [3:0] nb [4] = '{4'h1, 4'h2, 4'h3, 4'h4};
        int idx = 0;
        int seen = 0;
        logic [15:0] got_d = '0;
        logic [5:0]  got_a = '1;
        @(negedge clk); n_start = 1'b1; n_length = 7'd1;
        @(negedge clk); n_start = 1'b0;
        for (int n = 0; n < 40 && !n_done; n++) begin
            if (n_we) begin seen++; got_d = n_data; got_a = n_addr; end
            n_valid = n_ready && (idx < 4);
            n_data_in = (idx < 4) ? nb[idx] : 4'h0;
            if (n_valid) idx++;
            @(negedge clk);
        end
        n_valid = 1'b0;
        n_assert++;
        if (seen != 1 || got_a !== 6'd0 || got_d !== 16'h4321 || n_done !== 1'b1) begin
            n_fail++; $display("FAIL narrow_word: got %0d writes addr %0d data %h done %b, required 1 write addr 0 data 4321 done 1", seen, got_a, got_d, n_done);
        end
    endtask

    initial begin
        start_in = 1'b0; length_in = '0; data_in = '0; data_valid_in = 1'b0;
        n_start = 1'b0; n_length = '0; n_data_in = '0; n_valid = 1'b0;
        first_run = 1'b0; first_flags = '0;
        test_reset();
        test_back_to_back();
        test_error();
        test_random_gaps();
        test_full_depth();
        test_reset_midload();
        test_narrow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
